// File: rtl/serial_arith_pkg.sv
// Shared encodings for the bit-serial add/subtract controller.
// State and opcode constants plus the FSM state type.
package serial_arith_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_t;

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/bit_full_adder.sv
// One-bit full adder assembled from two half-adder cells.
// The carries of both half adders are ORed into the carry-out.
module bit_full_adder (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    logic w_s1;
    logic w_c1;
    logic w_c2;

    assign w_s1 = x ^ y;
    assign w_c1 = x & y;

    assign s    = w_s1 ^ ci;
    assign w_c2 = w_s1 & ci;

    assign co   = w_c1 | w_c2;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller: one full-adder cell reused
// over WIDTH clocks, LSB first, behind valid/ready handshakes.
module serial_adder_ctrl
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum_sh;
    logic [WIDTH-1:0] w_sum_nxt;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic             w_fa_s;
    logic             w_fa_c;
    logic             w_accept;
    logic             w_step;

    bit_full_adder u_fa (
        .x  (r_a_sh[0]),
        .y  (r_b_sh[0]),
        .ci (r_carry),
        .s  (w_fa_s),
        .co (w_fa_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Unused encoding 2'd3 falls into default and returns to IDLE.
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (r_cnt == CNT_LAST) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign w_accept = in_valid && in_ready;
    assign w_step   = (r_state == S_RUN);

    generate
        if (WIDTH == 1) begin : g_w1
            assign w_sum_nxt = w_fa_s;
        end else begin : g_wn
            assign w_sum_nxt = {w_fa_s, r_sum_sh[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_a_sh   <= a;
            r_b_sh   <= (op == OP_SUB) ? ~b : b;
            r_carry  <= (op == OP_SUB) ? 1'b1 : cin;
            r_sum_sh <= '0;
            r_cnt    <= '0;
        end else if (w_step) begin
            r_a_sh   <= r_a_sh >> 1;
            r_b_sh   <= r_b_sh >> 1;
            r_sum_sh <= w_sum_nxt;
            r_carry  <= w_fa_c;
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    assign sum  = r_sum_sh;
    assign cout = r_carry;

endmodule
